mem_burst_initiator: RTL and testbench
======================================

# mem_burst_initiator

Request-side master for one port of the 32x8 dual-port SRAM wrapper. Accepts burst read/write commands over a valid/ready interface and drives the port's CE/WE/A/D/WEM pins. Captures the port's Q output into a 2-entry response buffer, so read data is never lost under backpressure. One instance is placed per SRAM port (port 0 or port 1) inside the memory subsystem.

## Interface
- ADDR_W, 5, SRAM address width (32 words)
- DATA_W, 8, SRAM data and bit-mask width
- CLK  in  1  single clock, shared with the SRAM wrapper
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready
- req_we  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  ADDR_W  beats minus 1 (1..32 beats)
- wdata_valid / wdata_ready  in / out  1  write-beat handshake
- wdata  in  DATA_W  write beat data
- wmask  in  DATA_W  per-bit write enable, 1 = write
- rdata_valid / rdata_ready  out / in  1  read-beat handshake
- rdata  out  DATA_W  read beat data
- rdata_last  out  1  final beat of a read burst
- mem_ce  out  1  to wrapper CE, active high
- mem_we  out  1  to wrapper WE, 1 = write
- mem_a  out  ADDR_W  to wrapper A
- mem_d  out  DATA_W  to wrapper D
- mem_wem  out  DATA_W  to wrapper WEM
- mem_q  in  DATA_W  from wrapper Q

## Operation
- FSM states: IDLE, RD, WR.
- req_ready = (state == IDLE).
- On accept, capture addr, len, and we into base, beats_left = len, and beat_addr = req_addr.
  - Go to WR if we = 1; otherwise go to RD.
- RD issue condition: issue = (state == RD) & (fifo_count + inflight − pop < 2), where pop = rdata_valid & rdata_ready.
  - On issue: mem_ce = 1, mem_we = 0, mem_a = beat_addr.
  - beat_addr increments mod 32, so address 31 wraps to 0.
  - inflight is set for the next cycle.
  - The last flag (beats_left == 0) is carried with the inflight entry.
- Read capture: in the cycle after an issue, mem_q is valid. At the end of that cycle, {mem_q, last} is pushed into the FIFO.
- WR: wdata_ready = (state == WR).
  - On each wdata handshake: mem_ce = 1, mem_we = 1, mem_a = beat_addr, mem_d = wdata, mem_wem = wmask. The write completes at that edge.
  - Bits whose wmask bit is 0 are left unchanged in memory.
- Last beat: on the last issued beat (RD) or last handshake (WR), the FSM returns to IDLE.
  - A new command may be accepted while read data is still draining from the FIFO. Ordering is preserved because the FIFO is strictly in order.
- Read output: rdata_valid = (fifo_count != 0). rdata and rdata_last come from the FIFO head.
- Idle drive: mem_ce = 0 whenever no access is issued. mem_d and mem_wem are 0 when not writing.

## Timing
- Reset values: state = IDLE, req_ready = 1, wdata_ready = 0, rdata_valid = 0, rdata_last = 0, rdata = 0, mem_ce = 0, mem_we = 0, mem_a = 0, mem_d = 0, mem_wem = 0, FIFO empty, inflight = 0.
- Read latency:
  - Accept at edge T.
  - First mem_ce in cycle T+1.
  - mem_q valid in cycle T+2 and captured at its end.
  - rdata_valid asserted in cycle T+3.
- Throughput: with rdata_ready held high, one beat per cycle, so a 32-beat read ends with rdata_last in cycle T+34.
- Backpressure: with rdata_ready = 0, at most 2 beats are issued, then issue stalls. No data is dropped.
- Push and pop may occur in the same cycle; fifo_count is then unchanged.
- Write bursts take one cycle per wdata handshake. Bubbles in wdata_valid stall the burst with mem_ce = 0.
- Reset mid-burst: synchronous. The FSM, counters, FIFO, and inflight are all cleared, and a pending mem_q beat is discarded.

## Structure
- Package mem_init_pkg holds the state enum {IDLE, RD, WR}, ADDR_W/DATA_W defaults, and RSP_DEPTH = 2.
- Sub-module mem_rsp_fifo: a 2-entry synchronous FIFO of {last, data} with count output. It provides simultaneous push/pop and synchronous reset.

## Test plan
- Single read: SRAM preloaded with mem[5] = 0xA5; read addr = 5, len = 0. Expect rdata = 0xA5 and rdata_last = 1 in cycle T+3, and req_ready = 1 again in T+2.
- Wrapping read: addr = 30, len = 3. Expect mem_a sequence 30, 31, 0, 1; rdata_last only on the 4th beat.
- Masked write: mem[7] = 0xFF; write addr = 7, wdata = 0x00, wmask = 0x0F. Expect mem[7] = 0xF0, then read back 0xF0.
- Backpressure: 8-beat read with rdata_ready = 0 for 10 cycles. Expect exactly 2 mem_ce pulses, then after release 8 beats in order, none lost.
- Write stall: 4-beat write with wdata_valid toggling 1,0,1,0,… Expect mem_ce only on handshake cycles and final contents mem[a..a+3] = data.
- Reset mid-read: RST during beat 3 of 16. Expect next cycle rdata_valid = 0, mem_ce = 0, req_ready = 1, and no stale beat after reset.

Source files
------------

// File: rtl/mem_init_pkg.sv
// Shared types and sizing for the SRAM burst initiator and its response FIFO.
`timescale 1ns/1ps
package mem_init_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 8;
    localparam int RSP_DEPTH      = 2;
    localparam int RSP_PTR_W      = $clog2(RSP_DEPTH);
    localparam int RSP_CNT_W      = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry in-order response buffer of {last, data}; push and pop may coincide.
`timescale 1ns/1ps
module mem_rsp_fifo
    import mem_init_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     push_data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     head_o,
    output logic [RSP_CNT_W-1:0] count_o
);

    localparam logic [RSP_CNT_W-1:0] FULL = RSP_CNT_W'(RSP_DEPTH);

    logic [WIDTH-1:0]     entry_q [RSP_DEPTH];
    logic [RSP_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [RSP_CNT_W-1:0] count_q, count_d;
    logic                 do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the consumer gates head data with count != 0.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            entry_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst read/write master for one SRAM port; read beats land in a 2-entry buffer so
// backpressure on rdata never drops data.
`timescale 1ns/1ps
module mem_burst_initiator
    import mem_init_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic [DATA_W-1:0] mem_wem,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int OCC_W = RSP_CNT_W + 1;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    beat_addr_q, beat_addr_d;
    logic [ADDR_W-1:0]    beats_left_q, beats_left_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;

    logic [RSP_CNT_W-1:0] fifo_count;
    logic [DATA_W:0]      fifo_head;
    logic [OCC_W-1:0]     occupancy;
    logic                 pop, issue, wr_fire, last_beat;

    assign pop       = rdata_valid && rdata_ready;
    assign last_beat = (beats_left_q == '0);
    assign wr_fire   = (state_q == WR) && wdata_valid;

    // Buffered plus in-flight beats must leave room for the beat issued now.
    assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_q);
    assign issue     = (state_q == RD) && (occupancy < (OCC_W'(RSP_DEPTH) + OCC_W'(pop)));

    always_comb begin
        state_d         = state_q;
        beat_addr_d     = beat_addr_q;
        beats_left_d    = beats_left_q;
        inflight_d      = issue;
        inflight_last_d = issue && last_beat;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    beat_addr_d  = req_addr;
                    beats_left_d = req_len;
                    state_d      = req_we ? WR : RD;
                end
            end
            RD, WR: begin
                if (issue || wr_fire) begin
                    beat_addr_d  = beat_addr_q + 1'b1;
                    beats_left_d = beats_left_q - 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing inflight on reset discards any mem_q beat still owed by the SRAM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            beat_addr_q     <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_addr_q     <= beat_addr_d;
            beats_left_q    <= beats_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    mem_rsp_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, mem_q}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign req_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == WR);

    assign mem_ce  = issue || wr_fire;
    assign mem_we  = wr_fire;
    assign mem_a   = mem_ce  ? beat_addr_q : '0;
    assign mem_d   = wr_fire ? wdata       : '0;
    assign mem_wem = wr_fire ? wmask       : '0;

    assign rdata_valid = (fifo_count != '0);
    assign rdata       = rdata_valid ? fifo_head[DATA_W-1:0] : '0;
    assign rdata_last  = rdata_valid && fifo_head[DATA_W];

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench: a 32x8 masked-write SRAM model on the port, hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_burst_initiator;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr, req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata, wmask;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DW-1:0] rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_wem;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] sram   [32];
    logic [DW-1:0] golden [32];

    int            ce_cnt = 0;
    logic [AW-1:0] rd_addrs [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_burst_initiator dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wmask       (wmask),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_wem     (mem_wem),
        .mem_q       (mem_q)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 8'hA5;
        if (i == 7) return 8'hFF;
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous SRAM: registered Q, per-bit write mask, reloaded while RST is high.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) sram[i] <= init_val(i);
        end else if (mem_ce) begin
            if (mem_we) sram[mem_a] <= (sram[mem_a] & ~mem_wem) | (mem_d & mem_wem);
            else        mem_q <= sram[mem_a];
        end
    end

    always @(negedge CLK) begin
        if (mem_ce === 1'b1) begin
            ce_cnt++;
            if (mem_we === 1'b0) rd_addrs.push_back(mem_a);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called just after a clock edge; returns just after the accepting edge T (inside cycle T+1).
    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        @(negedge CLK);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic collect_read(input string tag, input logic [AW-1:0] addr, input int n,
                                input int budget, output int last_cyc);
        int beat = 0;
        int cyc  = 0;
        last_cyc = -1;
        while (beat < n && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (rdata_valid && rdata_ready) begin
                check({tag, "_data"}, 32'(rdata), 32'(golden[AW'(int'(addr) + beat)]));
                check({tag, "_last"}, 32'(rdata_last), 32'(beat == n - 1));
                if (beat == n - 1) last_cyc = cyc;
                beat++;
            end
        end
        check({tag, "_beats"}, 32'(beat), 32'(n));
        step();
    endtask

    task automatic run_write(input string tag, input logic [AW-1:0] addr, input int n,
                             input logic [DW-1:0] data [4], input logic [DW-1:0] mask,
                             input logic bubbles);
        int beat = 0;
        int cyc  = 0;
        while (beat < n && cyc < 40) begin
            wdata_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
            wdata       = data[beat];
            wmask       = mask;
            @(negedge CLK);
            if (wdata_valid && wdata_ready) begin
                check({tag, "_ce"},  32'(mem_ce),  32'd1);
                check({tag, "_we"},  32'(mem_we),  32'd1);
                check({tag, "_a"},   32'(mem_a),   32'(AW'(int'(addr) + beat)));
                check({tag, "_d"},   32'(mem_d),   32'(data[beat]));
                check({tag, "_wem"}, 32'(mem_wem), 32'(mask));
                golden[AW'(int'(addr) + beat)] =
                    (golden[AW'(int'(addr) + beat)] & ~mask) | (data[beat] & mask);
                beat++;
            end else begin
                check({tag, "_bubble_ce"}, 32'(mem_ce), 32'd0);
            end
            step();
            cyc++;
        end
        wdata_valid = 1'b0;
        wdata       = '0;
        wmask       = '0;
        check({tag, "_beats"}, 32'(beat), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        int            base, ce_base, last_cyc, stale;
        logic [DW-1:0] wd [4];
        logic [AW-1:0] exp_wrap [4];

        RST = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; wmask = '0; rdata_ready = 1'b0;
        for (int i = 0; i < 32; i++) golden[i] = init_val(i);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_req_ready",   32'(req_ready),   32'd1);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata_last",  32'(rdata_last),  32'd0);
        check("rst_rdata",       32'(rdata),       32'd0);
        check("rst_mem_ce",      32'(mem_ce),      32'd0);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_mem_a",       32'(mem_a),       32'd0);
        check("rst_mem_d",       32'(mem_d),       32'd0);
        check("rst_mem_wem",     32'(mem_wem),     32'd0);
        step();

        // Single read of mem[5] = 0xA5: issue in T+1, ready again in T+2, data in T+3
        rdata_ready = 1'b1;
        send_req(1'b0, 5'd5, 5'd0);
        @(negedge CLK);
        check("single_t1_ce",    32'(mem_ce),      32'd1);
        check("single_t1_we",    32'(mem_we),      32'd0);
        check("single_t1_a",     32'(mem_a),       32'd5);
        check("single_t1_ready", 32'(req_ready),   32'd0);
        @(negedge CLK);
        check("single_t2_ready", 32'(req_ready),   32'd1);
        check("single_t2_valid", 32'(rdata_valid), 32'd0);
        @(negedge CLK);
        check("single_t3_valid", 32'(rdata_valid), 32'd1);
        check("single_t3_data",  32'(rdata),       32'hA5);
        check("single_t3_last",  32'(rdata_last),  32'd1);
        @(negedge CLK);
        check("single_t4_valid", 32'(rdata_valid), 32'd0);
        step();

        // Wrapping read 30,31,0,1
        exp_wrap = '{5'd30, 5'd31, 5'd0, 5'd1};
        base = rd_addrs.size();
        send_req(1'b0, 5'd30, 5'd3);
        collect_read("wrap", 5'd30, 4, 20, last_cyc);
        check("wrap_ce_count", 32'(rd_addrs.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < rd_addrs.size())
                check("wrap_addr", 32'(rd_addrs[base + i]), 32'(exp_wrap[i]));
        end

        // Masked write: 0xFF with data 0x00, mask 0x0F -> 0xF0
        wd = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_req(1'b1, 5'd7, 5'd0);
        run_write("mwr", 5'd7, 1, wd, 8'h0F, 1'b0);
        check("mwr_sram7", 32'(sram[7]), 32'hF0);
        send_req(1'b0, 5'd7, 5'd0);
        collect_read("mwr_rb", 5'd7, 1, 10, last_cyc);

        // Backpressure: 8-beat read with rdata_ready low for 10 cycles
        rdata_ready = 1'b0;
        ce_base = ce_cnt;
        base    = rd_addrs.size();
        send_req(1'b0, 5'd8, 5'd7);
        repeat (10) @(negedge CLK);
        check("bp_ce_stalled", 32'(ce_cnt - ce_base), 32'd2);
        check("bp_valid_held", 32'(rdata_valid),      32'd1);
        check("bp_ready_busy", 32'(req_ready),        32'd0);
        step();
        rdata_ready = 1'b1;
        collect_read("bp", 5'd8, 8, 40, last_cyc);
        check("bp_ce_total", 32'(ce_cnt - ce_base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < rd_addrs.size())
                check("bp_addr", 32'(rd_addrs[base + i]), 32'(8 + i));
        end

        // Write with wdata_valid bubbles 1,0,1,0,...
        wd = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_req(1'b1, 5'd12, 5'd3);
        run_write("wstall", 5'd12, 4, wd, 8'hFF, 1'b1);
        check("wstall_m12", 32'(sram[12]), 32'hDE);
        check("wstall_m13", 32'(sram[13]), 32'hAD);
        check("wstall_m14", 32'(sram[14]), 32'hBE);
        check("wstall_m15", 32'(sram[15]), 32'hEF);
        send_req(1'b0, 5'd12, 5'd3);
        collect_read("wstall_rb", 5'd12, 4, 20, last_cyc);

        // Full 32-beat read: rdata_last lands in T+34
        send_req(1'b0, 5'd0, 5'd31);
        collect_read("full", 5'd0, 32, 60, last_cyc);
        check("full_last_cycle", 32'(last_cyc), 32'd34);

        // Reset asserted during beat 3 of a 16-beat read
        send_req(1'b0, 5'd0, 5'd15);
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        ce_base = ce_cnt;
        @(negedge CLK);
        check("rstmid_valid", 32'(rdata_valid), 32'd0);
        check("rstmid_ce",    32'(mem_ce),      32'd0);
        check("rstmid_ready", 32'(req_ready),   32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge CLK);
            if (rdata_valid) stale++;
        end
        check("rstmid_stale_beats", 32'(stale),            32'd0);
        check("rstmid_ce_after",    32'(ce_cnt - ce_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
